// File: rtl/cube_shader_pkg.sv
// Shared types and default palette for the cube face shading stage.
// Palette indices name the role each colour plays in the isometric cube view.
package cube_shader_pkg;

  localparam int PAL_DEPTH = 8;

  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    BG      = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    TOP     = 3'd3,
    VISITED = 3'd4,
    BLINK   = 3'd5
  } pal_idx_t;

  localparam rgb_t PAL_DEFAULT [PAL_DEPTH] = '{
    24'h000000,
    24'h2040A0,
    24'h103060,
    24'hE0E000,
    24'h00A0E0,
    24'hFFFFFF,
    24'h000000,
    24'h000000
  };

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Used to line up timing signals with pipelined pixel data.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg  [DEPTH];
  logic [WIDTH-1:0] stage_next [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_next[gi] = din;
      end else begin : g_rest
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/cube_face_shader.sv
// Turns cube_generator face flags into RGB888 with a double-buffered palette
// that swaps on the vsync rising edge, plus frame-counter driven blinking.
module cube_face_shader
  import cube_shader_pkg::*;
#(
  parameter int ALIGN_DELAY = 2,
  parameter int BLINK_BIT   = 4,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   left_face,
  input  logic                   right_face,
  input  logic                   top_face,
  input  logic                   qbert_top_face,
  input  logic                   pal_write,
  input  logic [2:0]             pal_address,
  input  logic [23:0]            pal_writedata,
  input  logic                   blink_enable,
  output logic [23:0]            rgb,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic [2:0] sync_dly;
  logic       de_dly;

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (ALIGN_DELAY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (reset),
    .din   ({de_in, hsync_in, vsync_in}),
    .dout  (sync_dly)
  );

  assign de_dly = sync_dly[2];

  // Frame start is taken from the undelayed vsync so the swap lands in blanking.
  logic vs_q_reg;
  logic frame_start;

  assign frame_start = vsync_in & ~vs_q_reg;

  rgb_t shadow_reg  [PAL_DEPTH];
  rgb_t shadow_next [PAL_DEPTH];
  rgb_t active_reg  [PAL_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < PAL_DEPTH; gi++) begin : g_shadow
      assign shadow_next[gi] = (pal_write && (pal_address == 3'(gi))) ?
                               pal_writedata : shadow_reg[gi];
    end
  endgenerate

  // active copies the pre-write shadow when a write coincides with frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        shadow_reg[i] <= PAL_DEFAULT[i];
        active_reg[i] <= PAL_DEFAULT[i];
      end
    end else begin
      if (frame_start) active_reg <= shadow_reg;
      shadow_reg <= shadow_next;
    end
  end

  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q_reg      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      vs_q_reg <= vsync_in;
      if (frame_start) frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
    end
  end

  logic blink_phase;
  rgb_t rgb_next;

  assign blink_phase = blink_enable & frame_cnt_reg[BLINK_BIT];

  always_comb begin
    rgb_next = '0;
    if (!de_dly)
      rgb_next = '0;
    else if (top_face && qbert_top_face)
      rgb_next = blink_phase ? active_reg[BLINK] : active_reg[VISITED];
    else if (top_face)
      rgb_next = active_reg[TOP];
    else if (left_face)
      rgb_next = active_reg[LEFT];
    else if (right_face)
      rgb_next = active_reg[RIGHT];
    else
      rgb_next = active_reg[BG];
  end

  rgb_t rgb_reg;
  logic de_out_reg;
  logic hsync_out_reg;
  logic vsync_out_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_reg       <= '0;
      de_out_reg    <= 1'b0;
      hsync_out_reg <= 1'b0;
      vsync_out_reg <= 1'b0;
    end else begin
      rgb_reg       <= rgb_next;
      de_out_reg    <= de_dly;
      hsync_out_reg <= sync_dly[1];
      vsync_out_reg <= sync_dly[0];
    end
  end

  assign rgb       = rgb_reg;
  assign de_out    = de_out_reg;
  assign hsync_out = hsync_out_reg;
  assign vsync_out = vsync_out_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_cube_face_shader.sv
// Bench for cube_face_shader: per-cycle comparison against a queue-based
// behavioural model, plus fixed colour/counter expectations per scenario.
module tb_cube_face_shader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        de_in = 0, hsync_in = 0, vsync_in = 0;
  logic        left_face = 0, right_face = 0, top_face = 0, qbert_top_face = 0;
  logic        pal_write = 0;
  logic [2:0]  pal_address = '0;
  logic [23:0] pal_writedata = '0;
  logic        blink_enable = 0;
  logic [23:0] rgb;
  logic        de_out, hsync_out, vsync_out;
  logic [7:0]  frame_cnt;

  cube_face_shader #(.ALIGN_DELAY(2), .BLINK_BIT(4), .FRAME_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .left_face(left_face), .right_face(right_face), .top_face(top_face),
    .qbert_top_face(qbert_top_face), .pal_write(pal_write), .pal_address(pal_address),
    .pal_writedata(pal_writedata), .blink_enable(blink_enable), .rgb(rgb),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] DEF [8] = '{24'h000000, 24'h2040A0, 24'h103060, 24'hE0E000,
                                      24'h00A0E0, 24'hFFFFFF, 24'h000000, 24'h000000};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: palettes as arrays, sync timing as a FIFO of past inputs.
  logic [23:0] m_shadow [8];
  logic [23:0] m_active [8];
  logic [7:0]  m_fcnt;
  logic        m_prev_vs;
  logic [2:0]  m_hist [$];
  logic [34:0] expv;
  wire  [34:0] got = {rgb, de_out, hsync_out, vsync_out, frame_cnt};

  function automatic void model_reset();
    m_shadow  = DEF;
    m_active  = DEF;
    m_fcnt    = '0;
    m_prev_vs = 1'b0;
    m_hist.delete();
    m_hist.push_back(3'b000);
    m_hist.push_back(3'b000);
    expv = '0;
  endfunction

  task automatic step(input logic de, input logic hs, input logic vs, input logic l,
                      input logic r, input logic t, input logic q, input logic w,
                      input logic [2:0] a, input logic [23:0] d, input logic bl);
    logic [2:0]  old;
    logic [23:0] col;
    de_in = de; hsync_in = hs; vsync_in = vs;
    left_face = l; right_face = r; top_face = t; qbert_top_face = q;
    pal_write = w; pal_address = a; pal_writedata = d; blink_enable = bl;
    @(posedge clk);
    old = m_hist.pop_front();
    if (!old[2])      col = 24'h0;
    else if (t && q)  col = (bl && m_fcnt[4]) ? m_active[5] : m_active[4];
    else if (t)       col = m_active[3];
    else if (l)       col = m_active[1];
    else if (r)       col = m_active[2];
    else              col = m_active[0];
    if (vs && !m_prev_vs) begin
      m_active = m_shadow;
      m_fcnt   = m_fcnt + 8'd1;
    end
    if (w) m_shadow[a] = d;
    m_prev_vs = vs;
    m_hist.push_back({de, hs, vs});
    expv = {col, old, m_fcnt};
    #1;
  endtask

  task automatic pix(input logic de, input logic l, input logic r, input logic t, input logic q);
    step(de, 1'b0, 1'b0, l, r, t, q, 1'b0, 3'd0, 24'h0, blink_enable);
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 3'd0, 24'h0, blink_enable);
    if (got !== expv) begin n_err++; $display("FAIL vs_pulse_hi: got %h exp %h", got, expv); end
    n_vec++;
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 3'd0, 24'h0, blink_enable);
    if (got !== expv) begin n_err++; $display("FAIL vs_pulse_lo: got %h exp %h", got, expv); end
    n_vec++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    de_in = 1; top_face = 1;
    repeat (3) @(negedge clk);
    if (got !== 35'h0) begin n_err++; $display("FAIL reset_outputs: got %h exp 0", got); end
    n_vec++;
    reset = 1'b1;
    de_in = 0; top_face = 0;
  endtask

  task automatic test_top_latency();
    for (int i = 0; i < 4; i++) begin
      pix(1, 0, 0, 1, 0);
      if (got !== expv) begin n_err++; $display("FAIL top_latency_model: cyc %0d got %h exp %h", i, got, expv); end
      n_vec++;
      if (i < 2 && de_out !== 1'b0) begin n_err++; $display("FAIL top_latency_early: cyc %0d de_out %b exp 0", i, de_out); end
      if (i < 2) n_vec++;
      if (i == 2 && (rgb !== 24'hE0E000 || de_out !== 1'b1)) begin
        n_err++; $display("FAIL top_latency_3: rgb %h de_out %b exp E0E000 1", rgb, de_out);
      end
      if (i == 2) n_vec++;
    end
  endtask

  task automatic test_left_right_de();
    for (int i = 0; i < 3; i++) begin
      pix(1, 1, 1, 0, 0);
      if (got !== expv) begin n_err++; $display("FAIL left_right_model: got %h exp %h", got, expv); end
      n_vec++;
    end
    if (rgb !== 24'h2040A0) begin n_err++; $display("FAIL left_priority: rgb %h exp 2040A0", rgb); end
    n_vec++;
    for (int i = 0; i < 3; i++) begin
      pix(0, 0, 0, 1, 0);
      if (got !== expv) begin n_err++; $display("FAIL de_gate_model: got %h exp %h", got, expv); end
      n_vec++;
    end
    if (rgb !== 24'h0) begin n_err++; $display("FAIL de_gate: rgb %h exp 000000", rgb); end
    n_vec++;
  endtask

  task automatic test_midframe_write();
    vs_pulse();
    pix(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 1'b1, 3'd1, 24'hFF0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pix(1, 1, 0, 0, 0);
      if (got !== expv) begin n_err++; $display("FAIL midframe_model: got %h exp %h", got, expv); end
      n_vec++;
    end
    if (rgb !== 24'h2040A0) begin n_err++; $display("FAIL midframe_hold: rgb %h exp 2040A0", rgb); end
    n_vec++;
    vs_pulse();
    for (int i = 0; i < 3; i++) begin
      pix(1, 1, 0, 0, 0);
      if (got !== expv) begin n_err++; $display("FAIL midframe_after_model: got %h exp %h", got, expv); end
      n_vec++;
    end
    if (rgb !== 24'hFF0000) begin n_err++; $display("FAIL midframe_swap: rgb %h exp FF0000", rgb); end
    n_vec++;
  endtask

  task automatic test_write_on_frame_start();
    step(0, 0, 1, 0, 0, 0, 0, 1'b1, 3'd3, 24'h123456, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 1'b0, 3'd0, 24'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pix(1, 0, 0, 1, 0);
      if (got !== expv) begin n_err++; $display("FAIL fs_write_model: got %h exp %h", got, expv); end
      n_vec++;
    end
    if (rgb !== 24'hE0E000) begin n_err++; $display("FAIL fs_write_same_frame: rgb %h exp E0E000", rgb); end
    n_vec++;
    vs_pulse();
    for (int i = 0; i < 3; i++) pix(1, 0, 0, 1, 0);
    if (rgb !== 24'h123456) begin n_err++; $display("FAIL fs_write_next_frame: rgb %h exp 123456", rgb); end
    n_vec++;
  endtask

  task automatic test_blink_and_wrap();
    int cnt;
    do_reset();
    blink_enable = 1'b1;
    for (int f = 0; f < 32; f++) begin
      for (int i = 0; i < 3; i++) pix(1, 0, 0, 1, 1);
      if (got !== expv) begin n_err++; $display("FAIL blink_model: frame %0d got %h exp %h", f, got, expv); end
      n_vec++;
      if (frame_cnt !== 8'(f) || rgb !== ((f & 16) != 0 ? 24'hFFFFFF : 24'h00A0E0)) begin
        n_err++; $display("FAIL blink_phase: frame %0d frame_cnt %0d rgb %h", f, frame_cnt, rgb);
      end
      n_vec++;
      vs_pulse();
    end
    blink_enable = 1'b0;
    cnt = 32;
    for (int f = 0; f < 228; f++) begin
      vs_pulse();
      cnt = (cnt + 1) % 256;
      if (frame_cnt !== 8'(cnt)) begin n_err++; $display("FAIL wrap_count: frame_cnt %0d exp %0d", frame_cnt, cnt); end
      n_vec++;
    end
    if (frame_cnt !== 8'd4) begin n_err++; $display("FAIL wrap_final: frame_cnt %0d exp 4", frame_cnt); end
    n_vec++;
  endtask

  task automatic test_vsync_hold();
    logic [7:0] start;
    start = frame_cnt;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, 1'b0, 3'd0, 24'h0, 1'b0);
      if (got !== expv) begin n_err++; $display("FAIL vs_hold_model: cyc %0d got %h exp %h", i, got, expv); end
      n_vec++;
    end
    pix(0, 0, 0, 0, 0);
    if (frame_cnt !== start + 8'd1) begin n_err++; $display("FAIL vs_hold_once: frame_cnt %0d exp %0d", frame_cnt, start + 8'd1); end
    n_vec++;
  endtask

  task automatic test_random();
    logic vs;
    vs = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) vs = ~vs;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), vs, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), 3'($urandom),
           24'($urandom), 1'($urandom_range(0, 15) != 0));
      if (got !== expv) begin n_err++; $display("FAIL random: cyc %0d got %h exp %h", i, got, expv); end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 0, 0, 0, 1'b1, 3'd1, 24'hABCDEF, 1'b0);
    for (int i = 0; i < 4; i++) pix(1, 1, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    if (rgb !== 24'h0 || de_out !== 1'b0 || frame_cnt !== 8'd0) begin
      n_err++; $display("FAIL async_reset: rgb %h de_out %b frame_cnt %0d exp 0", rgb, de_out, frame_cnt);
    end
    n_vec++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    vs_pulse();
    for (int i = 0; i < 3; i++) pix(1, 1, 0, 0, 0);
    if (rgb !== 24'h2040A0 || frame_cnt !== 8'd1) begin
      n_err++; $display("FAIL reset_defaults: rgb %h frame_cnt %0d exp 2040A0 1", rgb, frame_cnt);
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_top_latency();
    test_left_right_de();
    test_midframe_write();
    test_write_on_frame_start();
    test_blink_and_wrap();
    test_vsync_hold();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cube_face_shader.md
Name: cube_face_shader

Overview:
- Downstream pixel stage of cube_generator: converts its per-pixel face flags (left/right/top/qbert-visited top) into 24-bit RGB.
- Delays the display timing signals so the flags and the syncs reach the panel aligned.
- Holds a double-buffered 8-entry palette written by the NIOS; the active copy swaps only at frame start, so there is no mid-frame tearing.
- Provides frame-counter-based blinking of visited top faces.

Parameters:
- ALIGN_DELAY, 2, cycles between de_in/hsync_in/vsync_in and the matching face flags from cube_generator.
- BLINK_BIT, 4, frame_cnt bit that selects the blink phase (period = 2^(BLINK_BIT+1) frames).
- FRAME_CNT_W, 8, width of the internal frame counter.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- de_in  in  1  data enable, aligned with x_cnt/y_cnt.
- hsync_in  in  1  hsync, aligned with x_cnt/y_cnt.
- vsync_in  in  1  vsync, active-high, aligned with x_cnt/y_cnt.
- left_face  in  1  from cube_generator.
- right_face  in  1  from cube_generator.
- top_face  in  1  from cube_generator.
- qbert_top_face  in  1  from cube_generator.
- pal_write  in  1  palette write strobe, single cycle, no wait states.
- pal_address  in  3  palette index.
- pal_writedata  in  24  RGB888, {R,G,B}.
- blink_enable  in  1  enables blinking of visited tops.
- rgb  out  24  shaded pixel.
- de_out  out  1  delayed de.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- frame_cnt  out  FRAME_CNT_W  frames since reset.

Behaviour:
- Reset (reset=0, asynchronous): rgb, de_out, hsync_out, vsync_out, frame_cnt all 0; sync delay line cleared to 0.
- Reset also loads both shadow and active palettes with the package defaults:
  - idx0 BG 000000
  - idx1 LEFT 2040A0
  - idx2 RIGHT 103060
  - idx3 TOP E0E000
  - idx4 VISITED 00A0E0
  - idx5 BLINK FFFFFF
  - idx6 000000
  - idx7 000000
- Sync path: de/hsync/vsync pass through an ALIGN_DELAY-stage shift register, then one output register. Total latency is ALIGN_DELAY+1 cycles.
- Colour path: face flags are sampled as-is (already delayed ALIGN_DELAY by cube_generator). Colour is selected combinationally and registered once, so rgb is aligned with de_out.
- Colour select priority, first match wins:
  1. delayed de = 0 -> 000000.
  2. top_face & qbert_top_face -> active[5] if blink_enable & frame_cnt[BLINK_BIT], otherwise active[4].
  3. top_face -> active[3].
  4. left_face -> active[1].
  5. right_face -> active[2].
  6. otherwise -> active[0].
- qbert_top_face without top_face is ignored.
- Palette write: on pal_write=1, shadow[pal_address] <= pal_writedata at the clock edge. The active palette is unaffected until the next swap.
- Frame-start detect:
  - vs_q = registered vsync_in; frame_start = vsync_in & ~vs_q (rising edge, undelayed domain).
  - Consequence: the swap happens ALIGN_DELAY+1 cycles before vsync_out rises, i.e. inside vertical blank.
- On frame_start:
  - active <= shadow (all 8 entries, same cycle).
  - frame_cnt <= frame_cnt+1, wrapping from 2^FRAME_CNT_W-1 to 0.
- Write and frame_start in the same cycle: the swap copies the pre-write shadow contents. The new value becomes active at the following frame_start.
- Two writes to the same index within one frame: the last one wins.
- Swap mid-active-video cannot occur, because frame_start only fires on the vsync edge.
- vsync held high continuously: exactly one swap/increment. It does not re-fire until vsync has gone low and risen again.
- Reset mid-frame: all state returns to reset values and pending shadow writes are lost. The first vsync edge after reset counts as frame 1.
- blink_enable toggling takes effect on the next pixel (combinational into the colour select); no resynchronisation.

Decomposition:
- Package cube_shader_pkg:
  - typedef rgb_t (logic [23:0]).
  - enum pal_idx_t: BG=0, LEFT=1, RIGHT=2, TOP=3, VISITED=4, BLINK=5.
  - localparam array PAL_DEFAULT[8].
  - PAL_DEPTH=8.
- Sub-module sync_delay_line (parameters WIDTH, DEPTH; async active-low clear).
  - Instantiated once with WIDTH=3 for de/hsync/vsync.
  - Reusable by other stages needing the same alignment.

Test Plan:
- Reset then de_in=1, top_face=1, other flags 0, held ALIGN_DELAY+1=3 cycles -> rgb=E0E000 and de_out=1 exactly 3 cycles after de_in rises; during reset rgb=0.
- left_face=1 and right_face=1 together, de=1 -> rgb=2040A0; then de_in=0 with top_face=1 -> rgb=000000 on the matching cycle.
- pal_write idx1=FF0000 mid-frame -> rgb stays 2040A0 on left pixels until the vsync_in rising edge; after it, left pixels show FF0000.
- pal_write idx3=123456 on the exact frame_start cycle -> the next frame still shows E0E000; the frame after shows 123456.
- blink_enable=1, top+qbert flags, 32 vsync pulses -> rgb=00A0E0 while frame_cnt[4]=0 and FFFFFF while frame_cnt[4]=1; frame_cnt counts 0..31 with no skips.
- 256 vsync pulses -> frame_cnt wraps 255->0; vsync held high 100 cycles increments once; reset asserted mid-line restores default palette and rgb=0 immediately (asynchronously).
